// File: rtl/frac_prescaler_mc.sv
// Multi-channel fractional prescaler: each channel ticks at Fclk*mul/div, optionally for a fixed burst of ticks.
// Latency: tick/done/busy registered one cycle after the evaluating edge; backpressure: none (free-running outputs).
module frac_prescaler_mc #(
    parameter int BITS = 32,
    parameter int NCH  = 4,
    parameter int CW   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_clr,
    input  logic [NCH-1:0]      ch_en,
    input  logic [NCH-1:0]      ch_mode,
    input  logic [NCH-1:0]      cfg_load,
    input  logic [NCH*BITS-1:0] cfg_mul,
    input  logic [NCH*BITS-1:0] cfg_div,
    input  logic [NCH*CW-1:0]   cfg_burst,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      cfg_err
);

    typedef enum logic {IDLE, RUN} state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t          st_q;
        logic [BITS-1:0] acc_q, mul_q, div_q;
        logic [CW-1:0]   blen_q, cnt_q;
        logic            burst_q, hold_q;
        logic            tick_q, done_q, busy_q, err_q;

        logic [BITS:0]   sum;
        logic            hit;
        logic [BITS-1:0] acc_sub;
        logic [CW-1:0]   cnt_inc;

        assign sum     = {1'b0, acc_q} + {1'b0, mul_q};
        assign hit     = (sum >= {1'b0, div_q});
        assign acc_sub = acc_q + mul_q - div_q;
        assign cnt_inc = cnt_q + CW'(1);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st_q    <= IDLE;
                acc_q   <= '0;
                mul_q   <= '0;
                div_q   <= '0;
                blen_q  <= '0;
                cnt_q   <= '0;
                burst_q <= 1'b0;
                hold_q  <= 1'b0;
                tick_q  <= 1'b0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
            end else begin
                tick_q <= 1'b0;
                done_q <= 1'b0;
                if (cfg_load[i]) begin
                    mul_q  <= cfg_mul[i*BITS +: BITS];
                    div_q  <= cfg_div[i*BITS +: BITS];
                    blen_q <= cfg_burst[i*CW +: CW];
                    err_q  <= (cfg_div[i*BITS +: BITS] == '0) ||
                              (ch_mode[i] && (cfg_burst[i*CW +: CW] == '0));
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    st_q   <= IDLE;
                    busy_q <= 1'b0;
                end else if (st_q == IDLE) begin
                    // A finished burst stays parked until ch_en has been seen low.
                    if (ch_en[i] && !err_q && !hold_q) begin
                        st_q    <= RUN;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        burst_q <= ch_mode[i];
                    end
                end else if (!ch_en[i]) begin
                    st_q   <= IDLE;
                    busy_q <= 1'b0;
                end else if (sync_clr) begin
                    acc_q <= '0;
                end else if (hit) begin
                    // mul >= div saturates to one tick per cycle with a zero residue.
                    acc_q  <= (mul_q >= div_q) ? '0 : acc_sub;
                    tick_q <= 1'b1;
                    cnt_q  <= cnt_inc;
                    if (burst_q && (cnt_inc == blen_q)) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        st_q   <= IDLE;
                        hold_q <= 1'b1;
                    end
                end else begin
                    acc_q <= sum[BITS-1:0];
                end
                if (!ch_en[i]) begin
                    hold_q <= 1'b0;
                end
            end
        end

        assign tick[i]    = tick_q;
        assign done[i]    = done_q;
        assign busy[i]    = busy_q;
        assign cfg_err[i] = err_q;
    end

endmodule
